// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO geometry defaults, word type and the inverter client helper.
//   DWIDTH - data word width
//   DEPTH  - number of FIFO entries (power of two, >= 2)
//   AWIDTH - pointer width, log2(DEPTH)
package fifo_pkg;
    localparam int DWIDTH = 16;
    localparam int DEPTH  = 16;
    localparam int AWIDTH = 4;

    typedef logic [DWIDTH-1:0] word_t;

    // Transformation applied by the inverter client sitting between two FIFOs.
    function automatic word_t invert_word(input word_t w);
        return ~w;
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DWIDTH register array, one synchronous write port, one synchronous read port.
//   clk     - clock
//   we_i    - write enable; wdata_i stored at waddr_i on the rising edge
//   waddr_i - write address
//   wdata_i - write data
//   re_i    - read enable; entry at raddr_i captured into rdata_o on the rising edge
//   raddr_i - read address
//   rdata_o - registered read data, held while re_i is low
// Storage has no reset; a read and write to the same address return the old entry.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DWIDTH = fifo_pkg::DWIDTH,
    parameter int DEPTH  = fifo_pkg::DEPTH,
    parameter int AWIDTH = fifo_pkg::AWIDTH
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);
    logic [DWIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/fifo_buffer.sv
// fifo_buffer: synchronous FIFO with one-cycle registered read data and sticky overflow/underflow flags.
//   clk     - clock, all state updates on rising edge
//   rst     - asynchronous active-high reset
//   wr_i    - write request, di_i pushed on this edge when accepted
//   di_i    - write data
//   rd_i    - read request, head popped on this edge when accepted
//   do_o    - read data, valid the cycle after an accepted read, held otherwise
//   empty_o - count is 0
//   full_o  - count is DEPTH
//   count_o - number of stored entries
//   ovf_o   - sticky: write attempted while full without a simultaneous read
//   udf_o   - sticky: read attempted while empty
module fifo_buffer
    import fifo_pkg::*;
#(
    parameter int DWIDTH = fifo_pkg::DWIDTH,
    parameter int DEPTH  = fifo_pkg::DEPTH,
    parameter int AWIDTH = fifo_pkg::AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_i,
    input  logic [DWIDTH-1:0] di_i,
    input  logic              rd_i,
    output logic [DWIDTH-1:0] do_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AWIDTH:0]   count_o,
    output logic              ovf_o,
    output logic              udf_o
);
    localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(DEPTH);

    logic [AWIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              rd_seen_q, rd_seen_d;
    logic              do_wr, do_rd;
    logic [DWIDTH-1:0] mem_rdata;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == FULL_CNT;
    assign count_o = count_q;
    assign ovf_o   = ovf_q;
    assign udf_o   = udf_q;

    // A full FIFO still accepts a write when a read frees the head slot in the same edge.
    assign do_wr = wr_i & (~full_o | rd_i);
    assign do_rd = rd_i & ~empty_o;

    always_comb begin
        wptr_d    = do_wr ? wptr_q + 1'b1 : wptr_q;
        rptr_d    = do_rd ? rptr_q + 1'b1 : rptr_q;
        count_d   = count_q + (AWIDTH+1)'(do_wr) - (AWIDTH+1)'(do_rd);
        ovf_d     = ovf_q | (wr_i & full_o & ~rd_i);
        udf_d     = udf_q | (rd_i & empty_o);
        rd_seen_d = rd_seen_q | do_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            rd_seen_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            rd_seen_q <= rd_seen_d;
        end
    end

    // The memory read register has no reset, so do_o is masked to zero until the
    // first accepted read after reset; this gives an asynchronous clear of do_o.
    assign do_o = rd_seen_q ? mem_rdata : '0;

    fifo_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (do_wr),
        .waddr_i (wptr_q),
        .wdata_i (di_i),
        .re_i    (do_rd),
        .raddr_i (rptr_q),
        .rdata_o (mem_rdata)
    );
endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: directed self-checking bench with a queue reference model and an inverter client loop.
module tb_fifo_buffer;
    import fifo_pkg::*;

    localparam int N = 16;

    logic        clk, rst;
    logic        wr, rd;
    logic [15:0] di, dout;
    logic        empty, full, ovf, udf;
    logic [4:0]  count;

    logic        b_wr, b_rd;
    logic [15:0] b_di, b_do;
    logic        b_empty, b_full, b_ovf, b_udf;
    logic [4:0]  b_count;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    logic [15:0] q[$];
    logic [15:0] m_do;
    logic        m_ovf, m_udf;

    fifo_buffer u_dut (
        .clk(clk), .rst(rst), .wr_i(wr), .di_i(di), .rd_i(rd), .do_o(dout),
        .empty_o(empty), .full_o(full), .count_o(count), .ovf_o(ovf), .udf_o(udf)
    );

    fifo_buffer u_b (
        .clk(clk), .rst(rst), .wr_i(b_wr), .di_i(b_di), .rd_i(b_rd), .do_o(b_do),
        .empty_o(b_empty), .full_o(b_full), .count_o(b_count), .ovf_o(b_ovf), .udf_o(b_udf)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("model_do", 32'(dout), 32'(m_do));
            check("model_count", 32'(count), 32'(q.size()));
            check("model_empty", 32'(empty), 32'(q.size() == 0));
            check("model_full", 32'(full), 32'(q.size() == N));
            check("model_ovf", 32'(ovf), 32'(m_ovf));
            check("model_udf", 32'(udf), 32'(m_udf));
        end
    end

    task automatic model_clear();
        q.delete();
        m_do = '0;
        m_ovf = 0;
        m_udf = 0;
    endtask

    // Drive one cycle from a falling edge, apply the FIFO rules to the model at the
    // rising edge, and return at the next falling edge.
    task automatic step(input logic w, input logic r, input logic [15:0] d);
        bit e, f;
        wr = w;
        rd = r;
        di = d;
        @(posedge clk);
        e = q.size() == 0;
        f = q.size() == N;
        if (r && !e) m_do = q.pop_front();
        if (w && (!f || r)) q.push_back(d);
        if (w && f && !r) m_ovf = 1;
        if (r && e) m_udf = 1;
        @(negedge clk);
        wr = 0;
        rd = 0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1;
        model_clear();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        rst = 1; wr = 0; rd = 0; di = '0;
        b_wr = 0; b_rd = 0; b_di = '0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 0;
        chk_en = 1;
        @(negedge clk);
        check("reset_count", 32'(count), 0);
        check("reset_empty", 32'(empty), 1);
        check("reset_full", 32'(full), 0);
        check("reset_do", 32'(dout), 0);

        step(1, 0, 16'h0001);
        step(1, 0, 16'h00FF);
        step(1, 0, 16'hA5A5);
        step(0, 1, '0);
        check("order_do0", 32'(dout), 32'h0001);
        step(0, 1, '0);
        check("order_do1", 32'(dout), 32'h00FF);
        step(0, 1, '0);
        check("order_do2", 32'(dout), 32'hA5A5);
        check("order_empty", 32'(empty), 1);

        step(1, 0, 16'h1111);
        step(1, 0, 16'h2222);
        step(1, 0, 16'h3333);
        check("pre_rst_count", 32'(count), 3);
        #2 rst = 1;
        model_clear();
        #1;
        check("async_rst_empty", 32'(empty), 1);
        check("async_rst_full", 32'(full), 0);
        check("async_rst_count", 32'(count), 0);
        check("async_rst_do", 32'(dout), 0);
        @(negedge clk);
        rst = 0;
        step(1, 0, 16'h4444);
        step(0, 1, '0);
        check("post_rst_data", 32'(dout), 32'h4444);

        for (int i = 0; i < N; i++) step(1, 0, 16'(i));
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 16);
        step(1, 0, 16'hDEAD);
        check("ovf_flag", 32'(ovf), 1);
        check("ovf_count", 32'(count), 16);
        for (int i = 0; i < N; i++) begin
            step(0, 1, '0);
            check("drain_data", 32'(dout), 32'(i));
        end
        check("drain_empty", 32'(empty), 1);

        step(0, 1, '0);
        check("udf_flag", 32'(udf), 1);
        check("udf_do_hold", 32'(dout), 32'h000F);
        check("udf_count", 32'(count), 0);
        check("ovf_sticky", 32'(ovf), 1);

        reset_pulse();
        step(1, 1, 16'h1234);
        check("simul_empty_count", 32'(count), 1);
        check("simul_empty_do", 32'(dout), 0);
        check("simul_empty_udf", 32'(udf), 1);
        step(0, 1, '0);
        check("simul_empty_data", 32'(dout), 32'h1234);
        for (int i = 0; i < N; i++) step(1, 0, 16'h0100 + 16'(i));
        step(1, 1, 16'h0200);
        check("simul_full_count", 32'(count), 16);
        check("simul_full_ovf", 32'(ovf), 0);
        check("simul_full_do", 32'(dout), 32'h0100);
        for (int i = 0; i < N; i++) step(0, 1, '0);
        check("simul_full_last", 32'(dout), 32'h0200);

        reset_pulse();
        step(1, 0, 16'h3000);
        step(1, 0, 16'h3001);
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 16'h3002 + 16'(i));
            check("wrap_data", 32'(dout), 32'h3000 + 32'(i));
        end
        check("wrap_count", 32'(count), 2);

        reset_pulse();
        step(0, 1, '0);
        step(0, 1, '0);
        step(1, 0, 16'h00F0);
        step(0, 1, '0);
        b_wr = 1;
        b_di = invert_word(dout);
        @(negedge clk);
        b_wr = 0;
        b_rd = 1;
        @(negedge clk);
        b_rd = 0;
        check("client_out", 32'(b_do), 32'hFF0F);
        check("client_b_empty", 32'(b_empty), 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
